instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Parameter: none other.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 imem_req  output  1  SHALL be the instruction-memory read request.
REQ-006 imem_addr  output  32  SHALL be the word-aligned fetch address.
REQ-007 imem_ack  input  1  SHALL mark imem_rdata valid for the pending request.
REQ-008 imem_rdata  input  32  SHALL be the instruction word returned from memory.
REQ-009 instr  output  32  SHALL be the held instruction word.
REQ-010 opcode  output  6  SHALL be instr[31:26], feeding control decode.
REQ-011 funct  output  6  SHALL be instr[5:0], feeding control decode.
REQ-012 instr_valid  output  1  SHALL mark instr/opcode/funct/pc valid.
REQ-013 instr_accept  input  1  SHALL mark the held instruction as retired this cycle.
REQ-014 pc  output  32  SHALL be the address of the held instruction.
REQ-015 pc_plus4  output  32  SHALL be pc+4 (JAL link value).
REQ-016 Jump, Branch, JumpSel  input  1 each  SHALL be the control-decode outputs for the held instruction.
REQ-017 branch_taken  input  1  SHALL be the branch condition result (BNE: operands unequal).
REQ-018 jr_target  input  32  SHALL be the register value for JR.
REQ-019 halt  input  1  SHALL request fetch stop (SYSCALL).
REQ-020 fetch_err  output  1  SHALL flag a misaligned JR target (see Configuration).

Function
REQ-021 FSM states SHALL be IDLE, REQ, HOLD, HALTED.
REQ-022 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-023 In REQ, imem_req=1 and imem_addr=pc; on imem_ack, imem_rdata SHALL be captured into instr and the FSM SHALL go to HOLD; without ack, it SHALL stay in REQ with address stable.
REQ-024 imem_ack outside REQ SHALL be ignored.
REQ-025 In HOLD, instr_valid=1 and imem_req=0; instr and pc SHALL stay stable until instr_accept.
REQ-026 On instr_accept in HOLD, pc SHALL load the next PC and the FSM SHALL go to REQ (one idle request gap: next imem_req in the following cycle).
REQ-027 Next-PC priority SHALL be:
- Jump&JumpSel -> jr_target
- Jump&!JumpSel -> {pc_plus4[31:28], instr[25:0], 2'b00}
- Branch&branch_taken -> pc_plus4 + (sign-extended instr[15:0] << 2)
- else -> pc_plus4
REQ-028 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.
REQ-029 halt sampled with instr_accept in HOLD SHALL take priority: go to HALTED, pc unchanged, no further request.
REQ-030 halt outside HOLD+instr_accept SHALL be ignored.
REQ-031 HALTED SHALL be left only by reset; instr_valid=0 and imem_req=0 there.
REQ-032 Minimum fetch-to-valid latency SHALL be one cycle after imem_ack (instr_valid high the cycle after ack).

Reset
REQ-033 Asserting reset_n low SHALL immediately force: state IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, including mid-request; a pending ack SHALL be discarded.
REQ-034 imem_addr SHALL equal pc at all times; opcode, funct and pc_plus4 SHALL derive from instr and pc.

Configuration
REQ-035 With FETCH_ALIGN_CHECK_EN defined, a JR redirect with jr_target[1:0]!=0 SHALL go to HALTED and set fetch_err=1 (sticky until reset), with pc unchanged.
REQ-036 Without FETCH_ALIGN_CHECK_EN, jr_target[1:0] SHALL be forced to 0 and fetch_err SHALL be tied 0.

Verification
REQ-037 Reset release, ack in first REQ with rdata=32'h2008_0005 -> imem_addr=0, instr_valid next cycle, opcode=6'b001000, pc_plus4=4.
REQ-038 Ack delayed 3 cycles -> imem_req held 3+ cycles, imem_addr stable, instr_valid=0 until after ack.
REQ-039 pc=32'h0000_0010, Branch=1, branch_taken=1, instr[15:0]=16'hFFFE, accept -> next imem_addr=32'h0000_000C; J with instr[25:0]=26'h40 -> imem_addr=32'h0000_0100.
REQ-040 Jump=1, JumpSel=1, jr_target=32'h0000_0202, accept -> with macro: HALTED, fetch_err=1; without macro: imem_addr=32'h0000_0200.
REQ-041 halt=1 with instr_accept -> HALTED, imem_req stays 0 for 10+ cycles; reset_n low mid-REQ -> imem_req=0 the same cycle, pc=RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: requests one word at a time, holds it for decode, and
// computes the next PC. Define FETCH_ALIGN_CHECK_EN to trap misaligned JR targets.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        instr_accept,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        JumpSel,
  input  logic        branch_taken,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] instr_r;
  logic [31:0] pc_nxt_s;
  logic [31:0] jr_addr_s;
  logic [31:0] br_off_s;
  logic        jr_misalign_s;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_err_r;
  logic set_err_s;

  assign jr_addr_s     = jr_target;
  assign jr_misalign_s = Jump && JumpSel && (jr_target[1:0] != 2'b00);
  assign set_err_s     = (state_r == HOLD) && instr_accept && !halt && jr_misalign_s;
  assign fetch_err     = fetch_err_r;

  // Sticky misaligned-JR flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_err_r <= 1'b0;
    end else if (set_err_s) begin
      fetch_err_r <= 1'b1;
    end else begin
      fetch_err_r <= fetch_err_r;
    end
  end
`else
  // Low address bits of a JR target are simply dropped.
  assign jr_addr_s     = jr_target & 32'hFFFF_FFFC;
  assign jr_misalign_s = 1'b0;
  assign fetch_err     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; halt outranks any redirect when the instruction retires.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:   state_nxt_s = REQ;
      REQ: begin
        if (imem_ack) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = REQ;
        end
      end
      HOLD: begin
        if (!instr_accept) begin
          state_nxt_s = HOLD;
        end else if (halt || jr_misalign_s) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = REQ;
        end
      end
      HALTED: state_nxt_s = HALTED;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state_r)
      REQ:     imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  assign br_off_s = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};

  // Next-PC selection: JR, J, taken branch, then sequential.
  always_comb begin
    pc_nxt_s = pc_plus4;
    if (Jump && JumpSel) begin
      pc_nxt_s = jr_addr_s;
    end else if (Jump) begin
      pc_nxt_s = {pc_plus4[31:28], instr_r[25:0], 2'b00};
    end else if (Branch && branch_taken) begin
      pc_nxt_s = pc_plus4 + br_off_s;
    end else begin
      pc_nxt_s = pc_plus4;
    end
  end

  // Instruction capture on ack and PC update on retirement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r    <= RESET_PC;
      instr_r <= 32'h0000_0000;
    end else begin
      if ((state_r == REQ) && imem_ack) begin
        instr_r <= imem_rdata;
      end else begin
        instr_r <= instr_r;
      end
      if ((state_r == HOLD) && (state_nxt_s == REQ)) begin
        pc_r <= pc_nxt_s;
      end else begin
        pc_r <= pc_r;
      end
    end
  end

  assign imem_addr = pc_r;
  assign pc        = pc_r;
  assign pc_plus4  = pc_r + 32'd4;
  assign instr     = instr_r;
  assign opcode    = instr_r[31:26];
  assign funct     = instr_r[5:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the driver pushes each expected fetched word,
// a monitor pops and checks it whenever a new instruction becomes valid.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        instr_accept = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        Jump = 1'b0;
  logic        Branch = 1'b0;
  logic        JumpSel = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] jr_target = 32'h0;
  logic        halt = 1'b0;
  logic        fetch_err;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_valid = 1'b0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .opcode(opcode), .funct(funct),
    .instr_valid(instr_valid), .instr_accept(instr_accept),
    .pc(pc), .pc_plus4(pc_plus4),
    .Jump(Jump), .Branch(Branch), .JumpSel(JumpSel),
    .branch_taken(branch_taken), .jr_target(jr_target),
    .halt(halt), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every newly valid instruction is compared with the oldest expected fetch.
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_instr", instr, e.word);
        check("sb_pc", pc, e.addr);
        check("sb_pc_plus4", pc_plus4, e.addr + 32'd4);
        check("sb_opcode", {26'd0, opcode}, {26'd0, e.word[31:26]});
        check("sb_funct", {26'd0, funct}, {26'd0, e.word[5:0]});
      end
    end
    prev_valid = instr_valid;
  end

  task automatic wait_req();
    int k = 0;
    while (!imem_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_timeout", {31'd0, imem_req}, 32'd1);
  endtask

  // Serve one request after dly idle cycles; returns at the negedge after the ack.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] rdata, input int dly);
    wait_req();
    check("fetch_addr", imem_addr, addr);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check("wait_req_held", {31'd0, imem_req}, 32'd1);
      check("wait_addr_stable", imem_addr, addr);
      check("wait_no_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    sb.push_back('{word: rdata, addr: addr});
    @(negedge clk);
    imem_ack = 1'b0;
    check("valid_latency", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic accept(input logic j, input logic js, input logic b, input logic bt,
                        input logic [31:0] jr, input logic h);
    Jump = j; JumpSel = js; Branch = b; branch_taken = bt; jr_target = jr; halt = h;
    instr_accept = 1'b1;
    @(negedge clk);
    instr_accept = 1'b0;
    Jump = 1'b0; JumpSel = 1'b0; Branch = 1'b0; branch_taken = 1'b0; halt = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_instr", instr, 32'h0000_0000);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_first_req", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    fetch(32'h0000_0000, 32'h2008_0005, 0);
    check("first_opcode", {26'd0, opcode}, 32'h0000_0008);
    check("first_pc_plus4", pc_plus4, 32'h0000_0004);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

    halt = 1'b1;
    fetch(32'h0000_0004, 32'h0000_0020, 3);
    halt = 1'b0;

    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; halt = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0; halt = 1'b0;
    @(negedge clk);
    check("hold_instr_stable", instr, 32'h0000_0020);
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_pc_stable", pc, 32'h0000_0004);
    check("hold_no_req", {31'd0, imem_req}, 32'd0);

    accept(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    check("accept_gap_req", {31'd0, imem_req}, 32'd1);
    fetch(32'h0000_0008, 32'h1234_5678, 1);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch(32'h0000_000C, 32'h0000_0000, 0);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch(32'h0000_0010, 32'h1400_FFFE, 0);
    accept(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
    fetch(32'h0000_000C, 32'h0800_0040, 0);
    accept(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch(32'h0000_0100, 32'h03E0_0008, 0);
    accept(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0202, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 3; i++) begin
      check("jr_err_flag", {31'd0, fetch_err}, 32'd1);
      check("jr_err_no_req", {31'd0, imem_req}, 32'd0);
      check("jr_err_no_valid", {31'd0, instr_valid}, 32'd0);
      check("jr_err_pc", pc, 32'h0000_0100);
      @(negedge clk);
    end
`else
    fetch(32'h0000_0200, 32'h0000_000C, 0);
    check("jr_no_err", {31'd0, fetch_err}, 32'd0);
`endif

    do_reset();
    fetch(32'h0000_0000, 32'h0000_000C, 0);
    accept(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("halt_no_req", {31'd0, imem_req}, 32'd0);
      check("halt_no_valid", {31'd0, instr_valid}, 32'd0);
      check("halt_pc", pc, 32'h0000_0000);
      @(negedge clk);
    end

    do_reset();
    fetch(32'h0000_0000, 32'h0000_0008, 0);
    accept(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0);
    fetch(32'hFFFF_FFFC, 32'h2108_0001, 0);
    check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    fetch(32'h0000_0000, 32'hAAAA_5555, 0);

    do_reset();
    accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    wait_req();
    imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA; reset_n = 1'b0;
    #1;
    check("midreq_rst_req", {31'd0, imem_req}, 32'd0);
    check("midreq_rst_pc", pc, 32'h0000_0000);
    @(negedge clk);
    imem_ack = 1'b0;
    check("midreq_ack_discard", instr, 32'h0000_0000);
    check("midreq_no_valid", {31'd0, instr_valid}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
